// File: rtl/uart_alu.sv
// uart_alu: byte-framed ALU behind a UART byte interface.
// Request: opcode, A, B (MSB first); response: opcode, result (MSB first), flags.
module uart_alu #(
  parameter int OPERAND_BYTES  = 2,
  parameter int TIMEOUT_CYCLES = 24000
) (
  input  logic       hwclk,
  input  logic       resetn,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  output logic       busy,
  output logic       overrun,
  output logic       timeout_err,
  output logic [3:0] leds
);
  localparam int W  = 8 * OPERAND_BYTES;
  localparam int BW = W + 16;
  localparam int IW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [2:0] LAST = 3'(OPERAND_BYTES - 1);
  localparam logic [2:0] NRSP = 3'(OPERAND_BYTES + 2);
  localparam logic [IW-1:0] TMAX = IW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, RECV_A, RECV_B, CALC, SEND} state_t;

  state_t        state_q, state_d;
  logic [7:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [2:0]    cnt_q, cnt_d, rem_q, rem_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [3:0]    leds_q, leds_d;
  logic          overrun_q, overrun_d;
  logic [W:0]    sum;
  logic [W-1:0]  res;
  logic          cflag, tmo, legal;

  assign sum   = {1'b0, a_q} + {1'b0, b_q};
  assign res   = op_q == 8'h2B ? sum[W-1:0] : op_q == 8'h2D ? a_q - b_q :
                 op_q == 8'h26 ? a_q & b_q : a_q ^ b_q;
  assign cflag = op_q == 8'h2B ? sum[W] : op_q == 8'h2D ? a_q < b_q : 1'b0;
  assign legal = rx_byte inside {8'h2B, 8'h2D, 8'h26, 8'h5E};
  // Expiry is decided from the counter alone so a byte arriving in that same
  // cycle is free to open a new frame.
  assign tmo   = TIMEOUT_CYCLES != 0 && (state_q == RECV_A || state_q == RECV_B) && idle_q == TMAX;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    idle_d    = idle_q;
    buf_d     = buf_q;
    leds_d    = leds_q;
    overrun_d = overrun_q;
    case (state_q)
      RECV_A, RECV_B: begin
        if (rx_valid) begin
          idle_d = '0;
          cnt_d  = cnt_q + 3'd1;
          if (state_q == RECV_A) a_d = (a_q << 8) | W'(rx_byte);
          else b_d = (b_q << 8) | W'(rx_byte);
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = state_q == RECV_A ? RECV_B : CALC;
          end
        end else begin
          idle_d = TIMEOUT_CYCLES == 0 ? '0 : idle_q + 1'b1;
        end
      end
      CALC: begin
        buf_d     = {op_q, res, 6'b0, res == '0, cflag};
        rem_d     = NRSP;
        leds_d    = res[3:0];
        overrun_d = overrun_q | rx_valid;
        state_d   = SEND;
      end
      SEND: begin
        overrun_d = overrun_q | rx_valid;
        if (tx_ready) begin
          buf_d   = buf_q << 8;
          rem_d   = rem_q - 3'd1;
          state_d = rem_q == 3'd1 ? IDLE : SEND;
        end
      end
      default: ;
    endcase
    if (tmo) begin
      state_d = IDLE;
      cnt_d   = '0;
      idle_d  = '0;
    end
    if (rx_valid && (state_q == IDLE || tmo)) begin
      op_d   = rx_byte;
      cnt_d  = '0;
      idle_d = '0;
      if (legal) state_d = RECV_A;
      else begin
        buf_d   = {8'hEE, {(BW-8){1'b0}}};
        rem_d   = 3'd1;
        state_d = SEND;
      end
    end
  end

  always_ff @(posedge hwclk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      idle_q    <= '0;
      buf_q     <= '0;
      leds_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      idle_q    <= idle_d;
      buf_q     <= buf_d;
      leds_q    <= leds_d;
      overrun_q <= overrun_d;
    end
  end

  assign tx_byte     = buf_q[BW-1 -: 8];
  assign tx_valid    = state_q == SEND;
  assign busy        = state_q != IDLE;
  assign overrun     = overrun_q;
  assign timeout_err = tmo;
  assign leds        = leds_q;
endmodule

// File: tb/tb_uart_alu.sv
// tb_uart_alu: directed frames with a byte scoreboard for uart_alu.
module tb_uart_alu;
  localparam int TMO = 40;
  logic       hwclk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b1;
  logic [7:0] tx_byte;
  logic       tx_valid, busy, overrun, timeout_err;
  logic [3:0] leds;
  int         total = 0;
  int         bad = 0;
  logic [7:0] q[$];
  logic [7:0] held;
  logic       hold_v = 1'b0;

  uart_alu #(.OPERAND_BYTES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .hwclk(hwclk), .resetn(resetn), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_ready(tx_ready), .tx_byte(tx_byte), .tx_valid(tx_valid), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err), .leds(leds)
  );

  always #5 hwclk = ~hwclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge hwclk) begin
    if (resetn && tx_valid) begin
      if (hold_v) chk("tx_hold", {24'b0, tx_byte}, {24'b0, held});
      if (q.size() == 0) chk("tx_unexpected", {31'b0, tx_valid}, 32'd0);
      else if (tx_ready) chk("tx_byte", {24'b0, tx_byte}, {24'b0, q.pop_front()});
      hold_v = !tx_ready;
      held   = tx_byte;
    end else begin
      if (resetn && hold_v) chk("tx_drop", {31'b0, tx_valid}, 32'd1);
      hold_v = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge hwclk); #1;
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge hwclk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic frame(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] r, input logic [7:0] f);
    q.push_back(op); q.push_back(r[15:8]); q.push_back(r[7:0]); q.push_back(f);
    send_byte(op); send_byte(a[15:8]); send_byte(a[7:0]); send_byte(b[15:8]); send_byte(b[7:0]);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 500) begin
      @(posedge hwclk);
      n++;
    end
    #1;
    chk("done_in_budget", {31'b0, n < 500}, 32'd1);
  endtask

  initial begin
    int pulses;
    repeat (3) @(posedge hwclk);
    #1;
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_tx_byte", {24'b0, tx_byte}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_overrun", {31'b0, overrun}, 32'd0);
    chk("rst_timeout", {31'b0, timeout_err}, 32'd0);
    chk("rst_leds", {28'b0, leds}, 32'd0);
    resetn = 1'b1;

    frame(8'h2B, 16'h1234, 16'h0001, 16'h1235, 8'h00);
    chk("calc_no_tx", {31'b0, tx_valid}, 32'd0);
    chk("calc_busy", {31'b0, busy}, 32'd1);
    @(posedge hwclk); #1;
    chk("send_first_valid", {31'b0, tx_valid}, 32'd1);
    wait_done();
    chk("leds_add", {28'b0, leds}, 32'h5);

    frame(8'h2B, 16'hFFFF, 16'h0001, 16'h0000, 8'h03);
    wait_done();
    chk("leds_carry", {28'b0, leds}, 32'h0);
    frame(8'h2D, 16'h0001, 16'h0002, 16'hFFFF, 8'h01);
    wait_done();
    chk("leds_sub", {28'b0, leds}, 32'hF);
    frame(8'h5E, 16'hAA55, 16'hAA55, 16'h0000, 8'h02);
    wait_done();

    q.push_back(8'hEE);
    send_byte(8'h41);
    wait_done();
    frame(8'h26, 16'hF00F, 16'hFFFF, 16'hF00F, 8'h00);
    wait_done();
    chk("leds_and", {28'b0, leds}, 32'hF);

    send_byte(8'h2B);
    send_byte(8'h12);
    pulses = 0;
    repeat (TMO + 20) begin
      @(negedge hwclk);
      if (timeout_err) pulses++;
    end
    chk("timeout_pulses", pulses, 32'd1);
    chk("timeout_busy", {31'b0, busy}, 32'd0);
    frame(8'h2D, 16'h1234, 16'h0034, 16'h1200, 8'h00);
    wait_done();

    tx_ready = 1'b0;
    frame(8'h2B, 16'h1234, 16'h0001, 16'h1235, 8'h00);
    repeat (50) @(posedge hwclk);
    send_byte(8'h55);
    repeat (50) @(posedge hwclk);
    #1;
    chk("stall_overrun", {31'b0, overrun}, 32'd1);
    chk("stall_valid", {31'b0, tx_valid}, 32'd1);
    tx_ready = 1'b1;
    wait_done();

    tx_ready = 1'b0;
    frame(8'h5E, 16'h00FF, 16'h0F0F, 16'h0FF0, 8'h00);
    repeat (4) @(posedge hwclk);
    #1;
    resetn = 1'b0;
    #1;
    q.delete();
    chk("arst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("arst_tx_byte", {24'b0, tx_byte}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_overrun", {31'b0, overrun}, 32'd0);
    chk("arst_leds", {28'b0, leds}, 32'd0);
    repeat (2) @(posedge hwclk);
    #1;
    resetn = 1'b1;
    tx_ready = 1'b1;
    repeat (20) @(posedge hwclk);
    #1;
    chk("post_rst_busy", {31'b0, busy}, 32'd0);
    frame(8'h5E, 16'h1234, 16'h000F, 16'h123B, 8'h00);
    wait_done();
    chk("leds_final", {28'b0, leds}, 32'hB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
